// File: rtl/led_message_scroller_pkg.sv
// Shared definitions for the LED message scroller and the character decoder
// that sits downstream of it.
//   - state_e     : scroller control states
//   - DIR_*       : scroll direction encodings for the dir input
//   - CH_*        : character codes understood by the digit decoder
//   - DISPLAY_RST : window contents right after reset (identity message, ptr 0)
package led_message_scroller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int          CHAR_W   = 4;
    localparam logic [3:0]  CH_ZERO  = 4'h0;
    localparam logic [3:0]  CH_BLANK = 4'hF;

    localparam logic [15:0] DISPLAY_RST = 16'h0123;

endpackage

// File: rtl/led_message_scroller_prescaler.sv
// step_prescaler: free-running divider that produces a single-cycle tick every
// STEP_CYCLES counting edges. Shared with the digit-multiplex refresh logic.
//   clk   : system clock
//   reset : asynchronous active-low reset, clears the count
//   run   : count on this edge
//   clear : force the count to zero (wins over run)
//   tick  : high on the edge where the count wraps from STEP_CYCLES-1 to 0
module step_prescaler #(
    parameter int STEP_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // tick is combinational so the consumer acts on the very edge that wraps
    assign tick = run && (cnt_q == CNT_W'(STEP_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_message_scroller.sv
// led_message_scroller: holds a writable message of 4-bit character codes and
// presents a scrolling 4-character window to the four-digit LED driver.
//   clk          : system clock
//   reset        : asynchronous active-low reset (also restores the message)
//   enable       : scrolling permitted
//   pause        : freeze scrolling while enabled
//   dir          : 0 = window moves to higher indices, 1 = to lower indices
//   wr_en/wr_addr/wr_data : message write port, usable in any state
//   display_word : {mem[ptr], mem[ptr+1], mem[ptr+2], mem[ptr+3]} (mod MSG_LEN)
//   step_pulse   : one-cycle pulse after every pointer advance
//   ptr          : current window start index
//   busy         : high while in RUN
module led_message_scroller
    import led_message_scroller_pkg::*;
#(
    parameter int MSG_LEN     = 16,
    parameter int ADDR_W      = 4,
    parameter int STEP_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pause,
    input  logic              dir,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    output logic [15:0]       display_word,
    output logic              step_pulse,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        mem_q [MSG_LEN];
    logic [15:0]       display_q, display_d;
    logic              step_pulse_q;
    logic              busy_q;
    logic              pre_run;
    logic              pre_clear;
    logic              tick;
    logic              wr_ok;

    step_prescaler #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (pre_run),
        .clear (pre_clear),
        .tick  (tick)
    );

    // Window index with one spare bit so a non-power-of-2 MSG_LEN wraps by a
    // single conditional subtract instead of a modulo.
    function automatic logic [ADDR_W-1:0] win_idx(input logic [ADDR_W-1:0] base,
                                                  input logic [1:0]        off);
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + {{(ADDR_W-1){1'b0}}, off};
        if (sum >= (ADDR_W+1)'(MSG_LEN)) begin
            sum = sum - (ADDR_W+1)'(MSG_LEN);
        end
        return sum[ADDR_W-1:0];
    endfunction

    // Control: enable dominates everything; the prescaler only advances on
    // edges that stay in RUN, so the pausing edge freezes the count.
    always_comb begin
        state_d   = state_q;
        pre_run   = 1'b0;
        pre_clear = 1'b0;
        if (!enable) begin
            state_d   = ST_IDLE;
            pre_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = pause ? ST_PAUSE : ST_RUN;
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        pre_run = 1'b1;
                    end
                end
                ST_PAUSE: if (!pause) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (tick) begin
            if (dir == DIR_DOWN) begin
                ptr_d = (ptr_q == '0) ? ADDR_W'(MSG_LEN - 1) : ptr_q - ADDR_W'(1);
            end else begin
                ptr_d = (ptr_q == ADDR_W'(MSG_LEN - 1)) ? '0 : ptr_q + ADDR_W'(1);
            end
        end
    end

    // Window is built from the pre-edge ptr/mem, giving one cycle of latency.
    always_comb begin
        display_d = '0;
        for (int j = 0; j < 4; j++) begin
            display_d[15-4*j -: 4] = mem_q[win_idx(ptr_q, 2'(j))];
        end
    end

    assign wr_ok = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(MSG_LEN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            display_q    <= DISPLAY_RST;
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= 4'(i);
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            step_pulse_q <= tick;
            busy_q       <= (state_d == ST_RUN);
            display_q    <= display_d;
            if (wr_ok) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    assign display_word = display_q;
    assign step_pulse   = step_pulse_q;
    assign ptr          = ptr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_led_message_scroller.sv
module tb_led_message_scroller;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, pause, dir, wr_en;
    logic [3:0]  wr_addr, wr_data;
    logic [15:0] display_word, display_word12;
    logic        step_pulse, step_pulse12;
    logic [3:0]  ptr, ptr12;
    logic        busy, busy12;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_message_scroller #(.MSG_LEN(16), .ADDR_W(4), .STEP_CYCLES(SC), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pause(pause), .dir(dir),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .display_word(display_word), .step_pulse(step_pulse), .ptr(ptr), .busy(busy));

    led_message_scroller #(.MSG_LEN(12), .ADDR_W(4), .STEP_CYCLES(SC), .CNT_W(3)) dut12 (
        .clk(clk), .reset(reset), .enable(enable), .pause(pause), .dir(dir),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .display_word(display_word12), .step_pulse(step_pulse12), .ptr(ptr12), .busy(busy12));

    typedef struct {
        logic [15:0] disp;
        logic [3:0]  p;
        logic        pulse;
        logic        bsy;
    } exp_t;

    exp_t sbq[$];

    // reference model, one slot per instance (0: MSG_LEN 16, 1: MSG_LEN 12)
    int          m_mem   [2][16];
    int          m_state [2];   // 0 idle, 1 run, 2 pause
    int          m_ptr   [2];
    int          m_cnt   [2];
    logic [15:0] m_disp  [2];
    logic        m_pulse [2];
    logic        m_busy  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m_mem[k][i] = i;
            m_state[k] = 0;
            m_ptr[k]   = 0;
            m_cnt[k]   = 0;
            m_disp[k]  = 16'h0123;
            m_pulse[k] = 1'b0;
            m_busy[k]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int k, input logic en, input logic pa, input logic dr,
                              input logic we, input int wa, input int wd);
        int  len;
        bit  stp;
        len = (k == 0) ? 16 : 12;
        stp = 1'b0;
        for (int j = 0; j < 4; j++) begin
            m_disp[k][15-4*j -: 4] = 4'(m_mem[k][(m_ptr[k] + j) % len]);
        end
        if (!en) begin
            m_state[k] = 0;
            m_cnt[k]   = 0;
        end else if (m_state[k] == 0) begin
            m_state[k] = pa ? 2 : 1;
        end else if (m_state[k] == 1) begin
            if (pa) begin
                m_state[k] = 2;
            end else if (m_cnt[k] == SC - 1) begin
                m_cnt[k] = 0;
                stp      = 1'b1;
            end else begin
                m_cnt[k]++;
            end
        end else if (!pa) begin
            m_state[k] = 1;
        end
        if (stp) m_ptr[k] = dr ? (m_ptr[k] + len - 1) % len : (m_ptr[k] + 1) % len;
        if (we && wa < len) m_mem[k][wa] = wd;
        m_pulse[k] = stp;
        m_busy[k]  = (m_state[k] == 1);
    endtask

    // Called just after a rising edge: drive inputs, predict, clock, compare.
    task automatic drive(input logic en, input logic pa, input logic dr,
                         input logic we, input logic [3:0] wa, input logic [3:0] wd);
        exp_t e;
        enable  = en;
        pause   = pa;
        dir     = dr;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        for (int k = 0; k < 2; k++) begin
            model_edge(k, en, pa, dr, we, int'(wa), int'(wd));
            e.disp  = m_disp[k];
            e.p     = 4'(m_ptr[k]);
            e.pulse = m_pulse[k];
            e.bsy   = m_busy[k];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("disp16", display_word, e.disp);
        check("ptr16", ptr, e.p);
        check("pulse16", step_pulse, e.pulse);
        check("busy16", busy, e.bsy);
        e = sbq.pop_front();
        check("disp12", display_word12, e.disp);
        check("ptr12", ptr12, e.p);
        check("pulse12", step_pulse12, e.pulse);
        check("busy12", busy12, e.bsy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp"}, display_word, 16'h0123);
        check({tag, "_ptr"}, ptr, 4'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pulse"}, step_pulse, 1'b0);
        check({tag, "_disp12"}, display_word12, 16'h0123);
        check({tag, "_ptr12"}, ptr12, 4'd0);
    endtask

    // Entered just after a rising edge; reset drops mid-cycle, outputs are
    // checked before any further clock edge, released just after the next one.
    task automatic async_reset();
        #3 reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        enable = 1'b0;
        wr_en  = 1'b0;
        reset  = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; pause = 1'b0; dir = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
        model_reset();

        // reset held for three clocks
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;

        // scroll up: steps on edges 5 and 9
        for (int c = 1; c <= 10; c++) begin
            drive(1, 0, 0, 0, 4'd0, 4'd0);
            check("t2_pulse", step_pulse, (c == 5 || c == 9));
            if (c == 9)  check("t2_ptr", ptr, 4'd2);
            if (c == 10) check("t2_disp", display_word, 16'h2345);
        end
        drive(0, 0, 0, 0, 4'd0, 4'd0);

        // scroll down from ptr 0 wraps to the last entry
        async_reset();
        for (int c = 1; c <= 6; c++) begin
            drive(1, 0, 1, 0, 4'd0, 4'd0);
            if (c == 5) begin
                check("t3_ptr", ptr, 4'd15);
                check("t3_ptr12", ptr12, 4'd11);
            end
            if (c == 6) check("t3_disp", display_word, 16'hF012);
        end
        drive(0, 0, 0, 0, 4'd0, 4'd0);

        // pause after two RUN edges, resume two RUN edges before the step
        drive(1, 0, 0, 0, 4'd0, 4'd0);
        drive(1, 0, 0, 0, 4'd0, 4'd0);
        drive(1, 0, 0, 0, 4'd0, 4'd0);
        for (int c = 0; c < 10; c++) begin
            drive(1, 1, 0, 0, 4'd0, 4'd0);
            check("t4_paused_pulse", step_pulse, 1'b0);
        end
        drive(1, 0, 0, 0, 4'd0, 4'd0);
        check("t4_resume_pulse", step_pulse, 1'b0);
        drive(1, 0, 0, 0, 4'd0, 4'd0);
        check("t4_run1_pulse", step_pulse, 1'b0);
        drive(1, 0, 0, 0, 4'd0, 4'd0);
        check("t4_run2_pulse", step_pulse, 1'b1);
        check("t4_ptr", ptr, 4'd0);
        drive(0, 0, 0, 0, 4'd0, 4'd0);

        // write while idle
        async_reset();
        drive(0, 0, 0, 1, 4'd1, 4'hA);
        drive(0, 0, 0, 0, 4'd0, 4'd0);
        check("t5_idle_wr", display_word, 16'h0A23);

        // write coinciding with a step edge
        async_reset();
        for (int c = 1; c <= 4; c++) drive(1, 0, 0, 0, 4'd0, 4'd0);
        drive(1, 0, 0, 1, 4'd3, 4'hB);
        drive(1, 0, 0, 0, 4'd0, 4'd0);
        check("t5_step_wr", display_word, 16'h12B4);
        drive(0, 0, 0, 0, 4'd0, 4'd0);

        // out-of-range write on the 12-entry instance
        drive(0, 0, 0, 1, 4'd13, 4'h5);
        drive(0, 0, 0, 0, 4'd0, 4'd0);
        check("t5_oor_wr12", display_word12, 16'h12B4);

        // mid-count asynchronous reset at ptr 7
        async_reset();
        for (int c = 1; c <= 31; c++) begin
            drive(1, 0, 0, 0, 4'd0, 4'd0);
            if (c == 29) check("t6_ptr", ptr, 4'd7);
        end
        async_reset();
        drive(0, 0, 0, 0, 4'd0, 4'd0);
        check("t6_identity", display_word, 16'h0123);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/led_message_scroller.md
Name: led_message_scroller

Overview:
- Upstream feeder for the four-digit LED driver.
- Holds a small writable message of 4-bit character codes and presents a 4-character window as a 16-bit word (char3..char0), which the driver decodes and multiplexes onto an3..an0.
- Advances the window one position every STEP_CYCLES clocks, giving a scrolling display.
- Supports pause, direction control and runtime message writes.

Parameters:
- MSG_LEN, 16, number of characters in the message buffer (4..2^ADDR_W).
- ADDR_W, 4, width of the message pointer and write address.
- STEP_CYCLES, 25000000, clocks between scroll steps (>=2).
- CNT_W, 25, width of the step prescaler; must satisfy 2^CNT_W > STEP_CYCLES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset; reset=0 clears the block
- enable  in  1  1 = scrolling permitted
- pause  in  1  1 = freeze scrolling while enabled
- dir  in  1  0 = window moves toward higher indices (text scrolls left); 1 = toward lower indices
- wr_en  in  1  message write strobe
- wr_addr  in  ADDR_W  message write index
- wr_data  in  4  character code to write
- display_word  out  16  {char3,char2,char1,char0}; char3 = mem[ptr], char2 = mem[ptr+1], char1 = mem[ptr+2], char0 = mem[ptr+3], all indices mod MSG_LEN
- step_pulse  out  1  one-cycle pulse on every pointer advance
- ptr  out  ADDR_W  current window start index
- busy  out  1  1 when state = RUN

Behaviour:
- Reset (reset=0, asynchronous):
  - mem[i] = i mod 16.
  - ptr = 0, prescaler = 0, state = IDLE.
  - step_pulse = 0, busy = 0, display_word = 16'h0123.
- Reset release is synchronous in effect: the first active edge after reset=1 performs normal operation.
- States and transitions, evaluated every edge with priority top-down:
  - any state, enable=0 -> IDLE. Prescaler cleared; ptr held.
  - IDLE, enable=1 -> RUN if pause=0, else PAUSE.
  - RUN, pause=1 -> PAUSE. Prescaler frozen at its current value.
  - PAUSE, pause=0 -> RUN. Prescaler resumes from the frozen value.
- Prescaler:
  - Counts only in RUN.
  - At prescaler == STEP_CYCLES-1 it wraps to 0 and a step occurs on the same edge.
- Step:
  - ptr updates on the step edge: ptr+1 (dir=0) or ptr-1 (dir=1).
  - Wrap: MSG_LEN-1 -> 0 going up; 0 -> MSG_LEN-1 going down.
  - step_pulse = 1 for exactly the cycle following the step edge.
  - dir is sampled only at the step edge.
- Timing from entering RUN with prescaler=0: the first step occurs on the STEP_CYCLES-th RUN edge; subsequent steps follow every STEP_CYCLES RUN edges.
- Writes:
  - wr_en=1 with wr_addr < MSG_LEN writes mem[wr_addr] = wr_data at that edge, in any state including IDLE.
  - wr_addr >= MSG_LEN: the write is ignored with no side effects.
- display_word:
  - Registered and recomputed every edge from the current ptr and mem (post-update values of the previous edge).
  - Latency is one cycle after a ptr change or a write.
  - A write and a step on the same edge both take effect; the next display_word reflects both.
- Window index arithmetic: ADDR_W+1 bits with a conditional subtract of MSG_LEN, so non-power-of-2 MSG_LEN wraps correctly.
- Mid-operation reset: all state is lost immediately, including message contents; outputs return to reset values without waiting for clk.
- step_pulse never asserts in IDLE or PAUSE.
- busy is registered and equals (state == RUN).

Decomposition:
- Shared Verilog header (led_pkg.vh):
  - state encodings: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2.
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1.
  - Character-code constants shared with the character decoder (e.g. CH_BLANK).
- One sub-module, step_prescaler:
  - Inputs: clk, reset, run, clear.
  - Output: tick.
  - Parameters: STEP_CYCLES, CNT_W.
  - Reused by the digit-multiplex refresh logic.

Test Plan (STEP_CYCLES=4, MSG_LEN=16 unless noted):
1. Hold reset=0 for 3 clocks, then release -> display_word=16'h0123, ptr=0, busy=0, step_pulse=0.
2. enable=1, pause=0, dir=0 for 9 clocks -> step_pulse high in cycles 5 and 9; ptr=2; display_word=16'h2345 one cycle after the second step.
3. dir=1 from ptr=0, run one step -> ptr=15, display_word=16'hF012.
4. In RUN, assert pause after 2 RUN edges, hold 10 clocks, deassert -> no step during pause; next step exactly 2 RUN edges after release.
5. wr_en=1, wr_addr=1, wr_data=4'hA while in IDLE -> display_word=16'h0A23 one cycle later. With wr_addr=3 coinciding with a step edge (ptr 0->1) -> next display_word = {1,2,new,4}. A write with MSG_LEN=12 and wr_addr=13 -> no change.
6. Pulse reset=0 asynchronously mid-count at ptr=7 -> outputs return to reset values before the next clk edge; mem restored to identity.
